// File: rtl/pipe_pkg.sv
// Shared state encoding and screen/score constants for the pipe scheduler.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FREEZE = 2'd2
   } sched_state_t;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int SCORE_MAX = 9999;

   // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads the seed on reset.
module lfsr16
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) q <= seed;
      else       q <= {q[14:0], ^(q & LFSR_TAPS)};
   end

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls NUM_PIPES pipe slots left on a divided tick, respawns them on the right
// with a pseudo-random height, and counts pipes that pass the bird.
module pipe_scheduler
   import pipe_pkg::*;
#(
   parameter int          NUM_PIPES = 3,
   parameter int          START_X   = 210,
   parameter int          SPACING   = 200,
   parameter int          PIPE_W    = 52,
   parameter int          BIRD_X    = 90,
   parameter int          SPEED     = 1,
   parameter int          TICK_DIV  = 833334,
   parameter int          Y_MIN     = 100,
   parameter int          Y_MAX     = 380,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    game_en,
   output logic [10*NUM_PIPES-1:0] pipe_x,
   output logic [10*NUM_PIPES-1:0] pipe_y,
   output logic                    scroll_tick,
   output logic                    score_inc,
   output logic [13:0]             score,
   output logic [1:0]              sched_state
);

   localparam int          Y_RANGE = Y_MAX - Y_MIN + 1;
   localparam int          Y_MID   = Y_MIN + (Y_MAX - Y_MIN) / 2;
   localparam int          RING    = NUM_PIPES * SPACING;
   localparam int          DIV_W   = $clog2(TICK_DIV);
   localparam logic [15:0] SEED    = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;

   if (RING + START_X >= 1024) begin : g_bad_width
      $error("NUM_PIPES*SPACING + START_X must be below 1024");
   end
   if (Y_RANGE < 256 || Y_RANGE > 512) begin : g_bad_yrange
      $error("Y_MAX-Y_MIN+1 must lie in 256..512");
   end
   if (SPEED < 1 || SPEED > 8 || TICK_DIV < 2) begin : g_bad_speed
      $error("SPEED must be 1..8 and TICK_DIV at least 2");
   end
   if (NUM_PIPES < 1 || NUM_PIPES > 8) begin : g_bad_pipes
      $error("NUM_PIPES must be 1..8 so every LFSR window fits in 16 bits");
   end

   sched_state_t         state_q, state_d;
   logic [DIV_W-1:0]     div_q;
   logic [15:0]          lfsr_q;
   logic                 tick;
   logic [9:0]           x_q [NUM_PIPES];
   logic [9:0]           y_q [NUM_PIPES];
   logic [9:0]           x_d [NUM_PIPES];
   logic [9:0]           y_d [NUM_PIPES];
   logic [NUM_PIPES-1:0] passed;
   logic [3:0]           pass_cnt;
   logic [14:0]          score_sum;
   logic                 unused_lfsr;

   lfsr16 u_lfsr (.clk(clk), .reset(reset), .seed(SEED), .q(lfsr_q));

   // Upper LFSR bits feed no window when NUM_PIPES is small.
   assign unused_lfsr = ^lfsr_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (game_en)  state_d = ST_RUN;
         ST_RUN:  if (!game_en) state_d = ST_FREEZE;
         default: state_d = state_q;
      endcase
   end

   // Dropping game_en on the wrap cycle suppresses the tick.
   assign tick = (state_q == ST_RUN) && game_en && (div_q == DIV_W'(TICK_DIV - 1));

   for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
      logic       respawn;
      logic [9:0] r;
      logic [9:0] y_rand;

      assign respawn = x_q[i] < 10'(SPEED);
      assign r       = {1'b0, lfsr_q[8+i:i]};
      assign y_rand  = 10'(Y_MIN) + ((r >= 10'(Y_RANGE)) ? r - 10'(Y_RANGE) : r);
      assign x_d[i]  = respawn ? x_q[i] + 10'(RING - SPEED) : x_q[i] - 10'(SPEED);
      assign y_d[i]  = respawn ? y_rand : y_q[i];
      assign passed[i] = !respawn
                       && ({1'b0, x_q[i]} + 11'(PIPE_W) >= 11'(BIRD_X))
                       && ({1'b0, x_d[i]} + 11'(PIPE_W) <  11'(BIRD_X));

      assign pipe_x[10*i +: 10] = x_q[i];
      assign pipe_y[10*i +: 10] = y_q[i];
   end

   always_comb begin
      pass_cnt = '0;
      for (int i = 0; i < NUM_PIPES; i++) pass_cnt = pass_cnt + 4'(passed[i]);
   end

   assign score_sum = 15'(score) + 15'(pass_cnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the slot array is a handful of flops, not a RAM, so it is reset element by element.
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i] <= 10'(START_X + i * SPACING);
            y_q[i] <= 10'(Y_MID);
         end
         div_q       <= '0;
         score       <= '0;
         score_inc   <= 1'b0;
         scroll_tick <= 1'b0;
      end else begin
         scroll_tick <= tick;
         score_inc   <= tick && (|passed);
         if (state_q == ST_RUN && game_en) div_q <= tick ? '0 : div_q + DIV_W'(1);
         if (tick) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
               x_q[i] <= x_d[i];
               y_q[i] <= y_d[i];
            end
            score <= (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
         end
      end
   end

   assign sched_state = state_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed and randomized bench for pipe_scheduler against a cycle-level behavioural model.
module tb_pipe_scheduler;

   typedef struct packed {
      logic [7:0][9:0] x;
      logic [7:0][9:0] y;
      logic [13:0]     score;
      logic            inc;
      logic            stick;
      logic [1:0]      st;
      logic [19:0]     div;
      logic [15:0]     lfsr;
   } mdl_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, en0, rst1, en1;
   logic [29:0] pipe_x0, pipe_y0;
   logic        scroll_tick0, score_inc0;
   logic [13:0] score0;
   logic [1:0]  state0;
   logic [79:0] pipe_x1, pipe_y1;
   logic        scroll_tick1, score_inc1;
   logic [13:0] score1;
   logic [1:0]  state1;

   int   checks = 0;
   int   errors = 0;
   mdl_t m0, m1;

   pipe_scheduler #(.TICK_DIV(4)) dut0 (
      .clk(clk), .reset(rst0), .game_en(en0),
      .pipe_x(pipe_x0), .pipe_y(pipe_y0), .scroll_tick(scroll_tick0),
      .score_inc(score_inc0), .score(score0), .sched_state(state0)
   );

   pipe_scheduler #(.NUM_PIPES(8), .SPACING(8), .SPEED(8), .TICK_DIV(2)) dut1 (
      .clk(clk), .reset(rst1), .game_en(en1),
      .pipe_x(pipe_x1), .pipe_y(pipe_y1), .scroll_tick(scroll_tick1),
      .score_inc(score_inc1), .score(score1), .sched_state(state1)
   );

   function automatic logic [15:0] lfsr_next(logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // One clock edge of the game rules: n slots, spacing sp, speed spd, divider td.
   function automatic mdl_t step(mdl_t m, bit rst, bit en, int n, int sp, int spd, int td);
      mdl_t r;
      int   ox, nx, rnd, passes;
      bit   tick;
      r = m;
      r.inc = 1'b0;
      r.stick = 1'b0;
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r.x[i] = (i < n) ? 10'(210 + i * sp) : 10'd0;
            r.y[i] = (i < n) ? 10'd240 : 10'd0;
         end
         r.score = '0;
         r.st    = 2'd0;
         r.div   = '0;
         r.lfsr  = 16'hACE1;
         return r;
      end
      r.lfsr = lfsr_next(m.lfsr);
      tick = (m.st == 2'd1) && en && (int'(m.div) == td - 1);
      if (m.st == 2'd0 && en)  r.st = 2'd1;
      if (m.st == 2'd1 && !en) r.st = 2'd2;
      if (m.st == 2'd1 && en)  r.div = tick ? 20'd0 : m.div + 20'd1;
      if (tick) begin
         passes = 0;
         for (int i = 0; i < n; i++) begin
            ox = int'(m.x[i]);
            if (ox >= spd) begin
               nx = ox - spd;
               if (ox + 52 >= 90 && nx + 52 < 90) passes++;
            end else begin
               nx  = ox + n * sp - spd;
               rnd = (int'(m.lfsr) >> i) & 511;
               r.y[i] = 10'(100 + ((rnd >= 281) ? rnd - 281 : rnd));
            end
            r.x[i] = 10'(nx);
         end
         r.score = 14'((int'(m.score) + passes > 9999) ? 9999 : int'(m.score) + passes);
         r.inc   = (passes > 0);
         r.stick = 1'b1;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      m0 = step(m0, rst0, en0, 3, 200, 1, 4);
      m1 = step(m1, rst1, en1, 8, 8, 8, 2);
      #1;
      chk("x0", 80'(pipe_x0), 80'(m0.x[2:0]));
      chk("y0", 80'(pipe_y0), 80'(m0.y[2:0]));
      chk("tick0", 80'(scroll_tick0), 80'(m0.stick));
      chk("inc0", 80'(score_inc0), 80'(m0.inc));
      chk("score0", 80'(score0), 80'(m0.score));
      chk("state0", 80'(state0), 80'(m0.st));
      chk("x1", pipe_x1, m1.x);
      chk("y1", pipe_y1, m1.y);
      chk("tick1", 80'(scroll_tick1), 80'(m1.stick));
      chk("inc1", 80'(score_inc1), 80'(m1.inc));
      chk("score1", 80'(score1), 80'(m1.score));
      chk("state1", 80'(state1), 80'(m1.st));
   endtask

   initial begin
      int          k, cnt, pulses_dut, pulses_exp;
      logic [29:0] snap_x, snap_y;
      logic [79:0] ex1, ey1;
      m0 = '0;
      m1 = '0;
      rst0 = 1'b1; en0 = 1'b0; rst1 = 1'b1; en1 = 1'b0;

      // 1: reset, then idle with game_en low
      cyc(); cyc();
      rst0 = 1'b0;
      cnt = 0;
      for (int c = 0; c < 50; c++) begin
         cyc();
         cnt += int'(scroll_tick0);
      end
      chk("t1_state", 80'(state0), 80'd0);
      chk("t1_x", 80'(pipe_x0), 80'({10'd610, 10'd410, 10'd210}));
      chk("t1_y", 80'(pipe_y0), 80'({10'd240, 10'd240, 10'd240}));
      chk("t1_no_tick", 80'(cnt), 80'd0);

      // 2: enter RUN, first tick after 4 cycles, then every 4
      en0 = 1'b1;
      cyc();
      chk("t2_run", 80'(state0), 80'd1);
      k = 0;
      do begin cyc(); k++; end while (!scroll_tick0 && k < 20);
      chk("t2_first_tick", 80'(k), 80'd4);
      chk("t2_x209", 80'(pipe_x0[9:0]), 80'd209);
      for (int t = 0; t < 3; t++) begin
         k = 0;
         do begin cyc(); k++; end while (!scroll_tick0 && k < 20);
         chk("t2_gap", 80'(k), 80'd4);
      end

      // 3: pipe 0 crosses the bird
      k = 0;
      while (!score_inc0 && k < 1000) begin cyc(); k++; end
      chk("t3_found", 80'(score_inc0), 80'd1);
      chk("t3_x37", 80'(pipe_x0[9:0]), 80'd37);
      chk("t3_score", 80'(score0), 80'd1);
      k = 0;
      do begin cyc(); k++; end while (!scroll_tick0 && k < 8);
      chk("t3_no_repeat", 80'(score_inc0), 80'd0);
      chk("t3_score_hold", 80'(score0), 80'd1);

      // 4: pipe 0 respawns at the right with a new height
      k = 0;
      while (pipe_x0[9:0] != 10'd0 && k < 400) begin cyc(); k++; end
      k = 0;
      do begin cyc(); k++; end while (!scroll_tick0 && k < 8);
      chk("t4_x599", 80'(pipe_x0[9:0]), 80'd599);
      chk("t4_y_range", 80'(pipe_y0[9:0] >= 10'd100 && pipe_y0[9:0] <= 10'd380), 80'd1);
      chk("t4_y_model", 80'(pipe_y0[9:0]), 80'(m0.y[0]));
      chk("t4_x1", 80'(pipe_x0[19:10]), 80'd199);
      chk("t4_x2", 80'(pipe_x0[29:20]), 80'd399);

      // 5: drop game_en with the divider at 3, then freeze
      k = 0;
      while (!(m0.st == 2'd1 && m0.div == 20'd3) && k < 8) begin cyc(); k++; end
      en0 = 1'b0;
      snap_x = m0.x[2:0];
      snap_y = m0.y[2:0];
      cyc();
      chk("t5_no_tick", 80'(scroll_tick0), 80'd0);
      chk("t5_freeze", 80'(state0), 80'd2);
      chk("t5_x_hold", 80'(pipe_x0), 80'(snap_x));
      for (int c = 0; c < 100; c++) cyc();
      chk("t5_x_frozen", 80'(pipe_x0), 80'(snap_x));
      chk("t5_y_frozen", 80'(pipe_y0), 80'(snap_y));
      en0 = 1'b1;
      for (int c = 0; c < 20; c++) cyc();
      chk("t5_no_restart", 80'(state0), 80'd2);
      chk("t5_x_still", 80'(pipe_x0), 80'(snap_x));
      rst0 = 1'b1; en0 = 1'b0;
      cyc();
      rst0 = 1'b0;
      chk("t5_rst_x", 80'(pipe_x0), 80'({10'd610, 10'd410, 10'd210}));
      chk("t5_rst_y", 80'(pipe_y0), 80'({10'd240, 10'd240, 10'd240}));
      chk("t5_rst_score", 80'(score0), 80'd0);
      chk("t5_rst_state", 80'(state0), 80'd0);

      // Randomized enable/reset traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if (en0) en0 = ($urandom_range(0, 99) != 0);
         else     en0 = ($urandom_range(0, 7) == 0);
         rst0 = ($urandom_range(0, 149) == 0);
         cyc();
      end
      rst0 = 1'b0;

      // 6: saturate the score on the dense configuration
      rst1 = 1'b0; en1 = 1'b1;
      k = 0;
      while (score1 != 14'd9999 && k < 25000) begin cyc(); k++; end
      chk("t6_sat", 80'(score1), 80'd9999);
      pulses_dut = 0;
      pulses_exp = 0;
      for (int c = 0; c < 40; c++) begin
         cyc();
         pulses_dut += int'(score_inc1);
         pulses_exp += int'(m1.inc);
      end
      chk("t6_pulses", 80'(pulses_dut), 80'(pulses_exp));
      chk("t6_pulses_nz", 80'(pulses_dut > 0), 80'd1);
      chk("t6_sat_hold", 80'(score1), 80'd9999);
      k = 0;
      while (!(m1.st == 2'd1 && m1.div == 20'd1) && k < 4) begin cyc(); k++; end
      rst1 = 1'b1;
      cyc();
      rst1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ex1[10*i +: 10] = 10'(210 + 8 * i);
         ey1[10*i +: 10] = 10'd240;
      end
      chk("t6_rst_x", pipe_x1, ex1);
      chk("t6_rst_y", pipe_y1, ey1);
      chk("t6_rst_tick", 80'(scroll_tick1), 80'd0);
      chk("t6_rst_inc", 80'(score_inc1), 80'd0);
      chk("t6_rst_score", 80'(score1), 80'd0);
      chk("t6_rst_state", 80'(state1), 80'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
Sequences the scrolling pipe obstacles for the game engine.
- Owns the x/y placement of NUM_PIPES pipe slots and advances them left on a divided scroll tick while the game is enabled.
- Recycles each pipe to the right once it leaves the left edge, with a new pseudo-random height.
- Counts pipes the bird has passed.
- Sits between the game FSM (game_en, game_reset) and the per-pipe object engines (t_x/t_y inputs), and feeds the score display.

Parameters:
NUM_PIPES, 3, number of pipe slots
START_X, 210, reset x of pipe 0; pipe i resets to START_X + i*SPACING
SPACING, 200, horizontal distance between consecutive pipes (px)
PIPE_W, 52, pipe width (px)
BIRD_X, 90, bird left-edge x used for pass detection
SPEED, 1, px moved per scroll tick (1..8)
TICK_DIV, 833334, clk cycles per scroll tick (>=2)
Y_MIN, 100, minimum pipe y
Y_MAX, 380, maximum pipe y; Y_MAX-Y_MIN+1 must lie in 256..512
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset (hard_reset OR game_reset)
game_en  in  1  game in playing mode
pipe_x  out  10*NUM_PIPES  left-edge x per pipe, slot i at [10i+9:10i]
pipe_y  out  10*NUM_PIPES  top y per pipe, same packing
scroll_tick  out  1  one-cycle pulse on each scroll step
score_inc  out  1  one-cycle pulse when at least one pipe passed the bird
score  out  14  passed-pipe count, saturating at 9999
sched_state  out  2  current FSM state

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, and overrides all other inputs.
- Reset values:
  - pipe_x[i] = START_X + i*SPACING
  - pipe_y[i] = Y_MIN + (Y_MAX-Y_MIN)/2
  - score = 0; score_inc = 0; scroll_tick = 0
  - divider = 0; LFSR = LFSR_SEED; state = IDLE
- FSM, 2-bit encoding:
  - IDLE: positions held; divider held at 0. Goes to RUN when game_en = 1.
  - RUN: divider counts. Goes to FREEZE when game_en = 0.
  - FREEZE: everything held for game-over display. Leaves only on reset; game_en = 1 does not restart.
- Divider, RUN only:
  - Counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and the internal tick fires.
  - The scroll_tick output is registered, so it is visible the cycle after the tick.
  - On the RUN->FREEZE transition cycle no tick fires, even if the count equals TICK_DIV-1.
- Position update, same edge as the tick, 1-cycle latency to outputs:
  - If pipe_x[i] >= SPEED: new x = pipe_x[i] - SPEED.
  - Else (respawn): new x = pipe_x[i] + NUM_PIPES*SPACING - SPEED. This preserves spacing: with defaults, a pipe at x=0 respawns at 599.
  - Respawn y: r = LFSR[8+i:i]; R = Y_MAX-Y_MIN+1; new y = Y_MIN + (r >= R ? r-R : r).
  - A non-respawning pipe keeps its y.
  - Simultaneous respawns of several pipes use their own bit windows and are all legal.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every clock in all states except reset.
- Pass detection, per pipe, on a tick without respawn: passed when (old x + PIPE_W >= BIRD_X) and (new x + PIPE_W < BIRD_X). Compute at 11 bits, no wrap.
- Scoring:
  - score += number of passed pipes, saturating at 9999.
  - score_inc = 1 for one cycle, aligned with the updated pipe_x, when any pipe passed.
  - score_inc also pulses at saturation.
- Width rules: NUM_PIPES*SPACING + START_X must be < 1024; checked by an elaboration-time assertion.
- All outputs are registered; there are no combinational paths from game_en.

Decomposition:
- Package pipe_pkg holds:
  - state encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_FREEZE=2'd2
  - SCREEN_W=640, SCREEN_H=480, SCORE_MAX=9999
  - LFSR tap constant
- One sub-module, lfsr16: clk, reset, seed, q[15:0], free-running.
- Per-pipe update logic is a generate loop inside pipe_scheduler.

Test Plan:
All scenarios use TICK_DIV=4 with other parameters at defaults, except where a scenario overrides them.
1. Reset then hold game_en=0 for 50 cycles -> state IDLE; pipe_x = {610,410,210}; all pipe_y = 240; no scroll_tick.
2. Raise game_en -> first scroll_tick exactly 4 cycles into RUN; pipe0 x = 209 on the cycle after the tick; a tick every 4 cycles thereafter.
3. Run until pipe0 x+52 crosses 90 (x 38->37) -> single score_inc pulse; score = 1; no pulse on the next tick.
4. Run until pipe0 reaches x=0, then next tick -> pipe0 x = 599; pipe0 y in 100..380 and equal to the value computed from the LFSR model; pipe1 and pipe2 x unchanged in spacing.
5. Drop game_en mid-RUN with the divider at 3 -> no tick; state FREEZE; positions frozen for 100 cycles; game_en=1 does not resume; reset returns to case-1 values.
6. Preload-by-run with SPEED=8, score forced near 9999 via long run -> score holds at 9999; score_inc still pulses on each pass; a synchronous reset asserted on a tick cycle wins (outputs take reset values).
